// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: next-PC source encoding and default
// parameter values.
package pc_sequencer_pkg;

  localparam int PC_W_DEF      = 8;
  localparam int RAS_DEPTH_DEF = 4;
  localparam int RESET_PC_DEF  = 0;

  typedef enum logic [2:0] {
    SRC_RESET,
    SRC_HOLD,
    SRC_RET,
    SRC_CALL,
    SRC_BRANCH,
    SRC_REL,
    SRC_INC
  } next_src_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: a circular LIFO in which a push while full silently
// overwrites the oldest entry. The top entry is read combinationally.
module pc_ras
  import pc_sequencer_pkg::*;
#(
  parameter int W     = PC_W_DEF,
  parameter int DEPTH = RAS_DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // ptr_reg is the next free slot; when full it also points at the oldest
  // entry, so a push there discards exactly that one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else if (clear) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else if (push) begin
      ptr_reg <= ptr_reg + 1'b1;
      if (!full) count_reg <= count_reg + 1'b1;
    end else if (pop) begin
      ptr_reg   <= ptr_reg - 1'b1;
      count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr_reg] <= din;
  end

  assign top   = mem[ptr_reg - 1'b1];
  assign count = count_reg;
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with prioritised hold/return/call/branch/relative
// selection. Define PC_SEQUENCER_RAS_EN to build in the return-address stack.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF,
  parameter int RESET_PC  = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            power,
  input  logic            stop_en,
  input  logic            branch_en,
  input  logic            rel_en,
  input  logic [PC_W-1:0] rel_off,
  input  logic            call_en,
  input  logic            ret_en,
  input  logic [PC_W-1:0] branch_pc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] next_pc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            ras_unf
);

`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  localparam logic [PC_W-1:0] RST_VAL = PC_W'(RESET_PC);

  next_src_e       src;
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] ras_top;

  assign pc_inc = pc_reg + 1'b1;

  // Without the stack, ret is invisible and call degrades to a plain branch.
  always_comb begin
    src = SRC_INC;
    if (!power)                 src = SRC_RESET;
    else if (stop_en)           src = SRC_HOLD;
    else if (ret_en && RAS_ON)  src = ras_empty ? SRC_INC : SRC_RET;
    else if (call_en)           src = RAS_ON ? SRC_CALL : SRC_BRANCH;
    else if (branch_en)         src = SRC_BRANCH;
    else if (rel_en)            src = SRC_REL;
  end

  always_comb begin
    next_pc = pc_inc;
    case (src)
      SRC_RESET:            next_pc = RST_VAL;
      SRC_HOLD:             next_pc = pc_reg;
      SRC_RET:              next_pc = ras_top;
      SRC_CALL, SRC_BRANCH: next_pc = branch_pc;
      SRC_REL:              next_pc = pc_reg + rel_off;
      default:              next_pc = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_reg <= RST_VAL;
    else        pc_reg <= next_pc;
  end

  assign pc = pc_reg;

`ifdef PC_SEQUENCER_RAS_EN
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic             push;
  logic             pop;
  logic [CNT_W-1:0] ras_count;
  logic             ovf_reg;
  logic             unf_reg;

  assign push = (src == SRC_CALL);
  assign pop  = (src == SRC_RET);

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (!power),
    .din   (pc_inc),
    .top   (ras_top),
    .count (ras_count),
    .full  (ras_full),
    .empty (ras_empty)
  );

  // Sticky flags only see requests that actually won the priority selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_reg | (push & ras_full);
      unf_reg <= unf_reg | (power & !stop_en & ret_en & (ras_count == '0));
    end
  end

  assign ras_ovf = ovf_reg;
  assign ras_unf = unf_reg;
`else
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;
  assign ras_unf   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each directed step queues its expected
// post-edge state and a monitor compares it just after the rising edge.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  localparam logic [5:0] P = 6'b100000;
  localparam logic [5:0] S = 6'b010000;
  localparam logic [5:0] R = 6'b001000;
  localparam logic [5:0] C = 6'b000100;
  localparam logic [5:0] B = 6'b000010;
  localparam logic [5:0] L = 6'b000001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       power = 1'b0, stop_en = 1'b0, branch_en = 1'b0, rel_en = 1'b0;
  logic       call_en = 1'b0, ret_en = 1'b0;
  logic [7:0] rel_off = '0, branch_pc = '0;
  logic [7:0] pc, next_pc;
  logic       ras_empty, ras_full, ras_ovf, ras_unf;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [3:0] fl;   // {empty, full, ovf, unf}
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  pc_sequencer #(
    .PC_W      (8),
    .RAS_DEPTH (4),
    .RESET_PC  (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .power     (power),
    .stop_en   (stop_en),
    .branch_en (branch_en),
    .rel_en    (rel_en),
    .rel_off   (rel_off),
    .call_en   (call_en),
    .ret_en    (ret_en),
    .branch_pc (branch_pc),
    .pc        (pc),
    .next_pc   (next_pc),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Flags collapse to the stackless constants when the stack is not built.
  function automatic logic [3:0] fl(input bit e, input bit f, input bit o, input bit u);
    return RAS ? {e, f, o, u} : 4'b1000;
  endfunction

  task automatic step(input string name, input logic [5:0] ctl,
                      input logic [7:0] bpc, input logic [7:0] off,
                      input logic [7:0] epc, input logic [3:0] efl);
    exp_t e;
    @(negedge clk);
    {power, stop_en, ret_en, call_en, branch_en, rel_en} = ctl;
    branch_pc = bpc;
    rel_off   = off;
    e.name = name;
    e.pc   = epc;
    e.fl   = efl;
    sb_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      $display("[TB] %s: pc=%02h flags(e,f,o,u)=%b%b%b%b", mon_e.name, pc,
               ras_empty, ras_full, ras_ovf, ras_unf);
      chk({mon_e.name, "/pc"},    32'(pc),        32'(mon_e.pc));
      chk({mon_e.name, "/empty"}, 32'(ras_empty), 32'(mon_e.fl[3]));
      chk({mon_e.name, "/full"},  32'(ras_full),  32'(mon_e.fl[2]));
      chk({mon_e.name, "/ovf"},   32'(ras_ovf),   32'(mon_e.fl[1]));
      chk({mon_e.name, "/unf"},   32'(ras_unf),   32'(mon_e.fl[0]));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset/pc", 32'(pc), 32'h0);
    chk("reset/empty", 32'(ras_empty), 32'h1);
    chk("reset/flags", 32'({ras_full, ras_ovf, ras_unf}), 32'h0);
    #1 rst_n = 1'b1;

    // Free-running count through the wrap, then on to 0x10.
    for (int k = 1; k <= 272; k++)
      step($sformatf("inc%0d", k), P, 8'h00, 8'h00, 8'(k), fl(1, 0, 0, 0));

    // Single call / return.
    step("call80", P | C, 8'h80, 8'h00, 8'h80, fl(0, 0, 0, 0));
    step("seq81",  P,     8'h00, 8'h00, 8'h81, fl(0, 0, 0, 0));
    step("seq82",  P,     8'h00, 8'h00, 8'h82, fl(0, 0, 0, 0));
    step("seq83",  P,     8'h00, 8'h00, 8'h83, fl(0, 0, 0, 0));
    step("ret11",  P | R, 8'h00, 8'h00, RAS ? 8'h11 : 8'h84, fl(1, 0, 0, 0));

    // Five nested calls overflow a depth-4 stack.
    step("br20",   P | B, 8'h20, 8'h00, 8'h20, fl(1, 0, 0, 0));
    step("call30", P | C, 8'h30, 8'h00, 8'h30, fl(0, 0, 0, 0));
    step("call40", P | C, 8'h40, 8'h00, 8'h40, fl(0, 0, 0, 0));
    step("call50", P | C, 8'h50, 8'h00, 8'h50, fl(0, 0, 0, 0));
    step("call60", P | C, 8'h60, 8'h00, 8'h60, fl(0, 1, 0, 0));
    step("call70", P | C, 8'h70, 8'h00, 8'h70, fl(0, 1, 1, 0));
    step("ret_a",  P | R, 8'h00, 8'h00, RAS ? 8'h61 : 8'h71, fl(0, 0, 1, 0));
    step("ret_b",  P | R, 8'h00, 8'h00, RAS ? 8'h51 : 8'h72, fl(0, 0, 1, 0));
    step("ret_c",  P | R, 8'h00, 8'h00, RAS ? 8'h41 : 8'h73, fl(0, 0, 1, 0));
    step("ret_d",  P | R, 8'h00, 8'h00, RAS ? 8'h31 : 8'h74, fl(1, 0, 1, 0));
    step("ret_unf", P | R, 8'h00, 8'h00, RAS ? 8'h32 : 8'h75, fl(1, 0, 1, 1));

    // Relative jumps, negative and wrapping, and masked by stop.
    step("br05",   P | B, 8'h05, 8'h00, 8'h05, fl(1, 0, 1, 1));
    step("rel_m6", P | L, 8'h00, 8'hFA, 8'hFF, fl(1, 0, 1, 1));
    #1 chk("rel_m6/next_pc", 32'(next_pc), 32'hFF);
    step("rel_p3", P | L, 8'h00, 8'h03, 8'h02, fl(1, 0, 1, 1));
    step("br05b",  P | B, 8'h05, 8'h00, 8'h05, fl(1, 0, 1, 1));
    step("stoprel", P | S | L, 8'h00, 8'hFA, 8'h05, fl(1, 0, 1, 1));

    // Masked stack requests, then power-down with three entries stacked.
    step("call90", P | C, 8'h90, 8'h00, 8'h90, fl(0, 0, 1, 1));
    step("callA0", P | C, 8'hA0, 8'h00, 8'hA0, fl(0, 0, 1, 1));
    step("callB0", P | C, 8'hB0, 8'h00, 8'hB0, fl(0, 0, 1, 1));
    step("stop_rc", P | S | R | C, 8'h33, 8'h00, 8'hB0, fl(0, 0, 1, 1));
    step("retA1",  P | R, 8'h00, 8'h00, RAS ? 8'hA1 : 8'hB1, fl(0, 0, 1, 1));
    step("callC0", P | C, 8'hC0, 8'h00, 8'hC0, fl(0, 0, 1, 1));
    step("pwr_off", C, 8'h44, 8'h00, 8'h00, fl(1, 0, 1, 1));
    #1 chk("pwr_off/next_pc", 32'(next_pc), 32'h00);
    step("pwr_ret", P | R, 8'h00, 8'h00, 8'h01, fl(1, 0, 1, 1));

    // Asynchronous reset between edges with a non-empty stack.
    step("call50b", P | C, 8'h50, 8'h00, 8'h50, fl(0, 0, 1, 1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst/pc", 32'(pc), 32'h0);
    chk("async_rst/empty", 32'(ras_empty), 32'h1);
    chk("async_rst/flags", 32'({ras_full, ras_ovf, ras_unf}), 32'h0);
    @(posedge clk);
    #1 chk("rst_hold/pc", 32'(pc), 32'h0);
    #1 rst_n = 1'b1;
    step("post_ret",  P | R, 8'h00, 8'h00, 8'h01, fl(1, 0, 0, 1));
    step("post_call", P | C, 8'h80, 8'h00, 8'h80, fl(0, 0, 0, 1));
    step("post_ret2", P | R, 8'h00, 8'h00, RAS ? 8'h02 : 8'h81, fl(1, 0, 0, 1));

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drain", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
